// File: rtl/mul_pkg.sv
// Shared types and constants for the RV32M multiply issue control.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } mul_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct3;
    logic [31:0] result;
  } mul_cache_entry_t;

  function automatic logic tag_match(input mul_cache_entry_t e,
                                     input logic [31:0]      a,
                                     input logic [31:0]      b,
                                     input logic [2:0]       funct3);
    return e.valid && (e.a == a) && (e.b == b) && (e.funct3 == funct3);
  endfunction

endpackage

// File: rtl/mul_result_cache.sv
// One-entry last-multiply cache: tag compare against the live EX operands.
// Latency: hit is combinational from the compare inputs; loads land next cycle.
// Backpressure: none, load and invalidate are accepted every cycle.
module mul_result_cache
  import mul_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmp_a_i,
  input  logic [31:0] cmp_b_i,
  input  logic [2:0]  cmp_funct3_i,
  output logic        hit_o,
  output logic [31:0] hit_result_o,
  input  logic        load_i,
  input  logic [31:0] load_a_i,
  input  logic [31:0] load_b_i,
  input  logic [2:0]  load_funct3_i,
  input  logic [31:0] load_result_i,
  input  logic        inval_i
);

  mul_cache_entry_t entry_q;
  mul_cache_entry_t entry_d;

  assign hit_o        = EN && tag_match(entry_q, cmp_a_i, cmp_b_i, cmp_funct3_i);
  assign hit_result_o = entry_q.result;

  // Invalidate wins so an aborted operation can never leave a stale tag behind.
  always_comb begin
    entry_d = entry_q;
    if (inval_i) begin
      entry_d.valid = 1'b0;
    end else if (load_i && EN) begin
      entry_d.valid  = 1'b1;
      entry_d.a      = load_a_i;
      entry_d.b      = load_b_i;
      entry_d.funct3 = load_funct3_i;
      entry_d.result = load_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// EX-stage multiply issue control: captures operands, pulses the multiplier, holds the result for WB.
// Latency: miss = start pulse 1 cycle after accept, result 2+L cycles after accept; cache hit = 1 cycle.
// Backpressure: stalls EX from accept until the wb_ready cycle; flush aborts immediately.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_mul,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic [4:0]  ex_rd,
  input  logic        flush_ex,
  output logic        stall_ex,
  output logic        mul_valid,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [2:0]  mul_funct3,
  output logic        mul_flush,
  input  logic [31:0] mul_y,
  input  logic        mul_done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ready,
  output logic        timeout_err
);

  localparam int unsigned    CW       = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  mul_state_t    state_q, state_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [2:0]    f3_q, f3_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic          accept;
  logic          cache_hit;
  logic [31:0]   cache_result;
  logic          cache_load;
  logic          cache_inval;

  assign accept = (state_q == IDLE) && ex_valid && ex_is_mul && !flush_ex;

  mul_result_cache #(
    .EN (CACHE_EN)
  ) u_cache (
    .clk           (clk),
    .rst           (rst),
    .cmp_a_i       (ex_a),
    .cmp_b_i       (ex_b),
    .cmp_funct3_i  (ex_funct3),
    .hit_o         (cache_hit),
    .hit_result_o  (cache_result),
    .load_i        (cache_load),
    .load_a_i      (a_q),
    .load_b_i      (b_q),
    .load_funct3_i (f3_q),
    .load_result_i (mul_y),
    .inval_i       (cache_inval)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    terr_d      = terr_q;
    cache_load  = 1'b0;
    cache_inval = 1'b0;
    mul_valid   = 1'b0;
    mul_flush   = 1'b0;
    wb_valid    = 1'b0;
    stall_ex    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = ex_a;
          b_d      = ex_b;
          f3_d     = ex_funct3;
          rd_d     = ex_rd;
          stall_ex = 1'b1;
          if (cache_hit) begin
            result_d = cache_result;
            state_d  = DONE;
          end else begin
            state_d  = ISSUE;
          end
        end
      end

      // A flush here suppresses the start pulse so nothing is left in flight.
      ISSUE: begin
        if (flush_ex) begin
          state_d = IDLE;
        end else begin
          mul_valid = 1'b1;
          stall_ex  = 1'b1;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        mul_flush = flush_ex;
        if (flush_ex) begin
          state_d = IDLE;
        end else begin
          stall_ex = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          if (mul_done) begin
            result_d   = mul_y;
            cache_load = 1'b1;
            state_d    = DONE;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            terr_d      = 1'b1;
            result_d    = '0;
            cache_inval = 1'b1;
            state_d     = DONE;
          end
        end
      end

      DONE: begin
        if (flush_ex) begin
          state_d = IDLE;
        end else begin
          wb_valid = 1'b1;
          stall_ex = !wb_ready;
          if (wb_ready) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
    end
  end

  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign mul_funct3  = f3_q;
  assign wb_rd       = rd_q;
  assign wb_data     = result_q;
  assign timeout_err = terr_q;

endmodule
